// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer FIFOs (ALU, LS) share one registered CDB broadcast
// slot under round-robin arbitration, with empty-FIFO bypass and misbranch flush.
module cdb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    misbranch_flag,
  input  logic                    alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] alu_rob_id,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  output logic                    alu_ready,
  input  logic                    ls_valid,
  input  logic [ROB_ID_WIDTH-1:0] ls_rob_id,
  input  logic [DATA_WIDTH-1:0]   ls_result,
  output logic                    ls_ready,
  output logic                    cdb_valid,
  output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
  output logic [DATA_WIDTH-1:0]   cdb_result,
  output logic                    cdb_src,
  output logic                    overflow_err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic        SrcAlu = 1'b0;
  localparam logic        SrcLs  = 1'b1;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   data;
  } entry_t;

  entry_t          mem_q    [2][FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q [2];
  logic [PtrW-1:0] rd_ptr_d [2];
  logic [PtrW-1:0] wr_ptr_q [2];
  logic [PtrW-1:0] wr_ptr_d [2];
  logic [CntW-1:0] count_q  [2];
  logic [CntW-1:0] count_d  [2];

  logic last_grant_q, last_grant_d;
  logic cdb_valid_q, cdb_valid_d;
  logic cdb_src_q, cdb_src_d;
  logic overflow_q, overflow_d;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_WIDTH-1:0]   cdb_result_q, cdb_result_d;

  entry_t in_entry   [2];
  entry_t cand_entry [2];
  logic   push  [2];
  logic   empty [2];
  logic   full  [2];
  logic   cand  [2];
  logic   grant [2];
  logic   deq   [2];
  logic   enq   [2];
  logic   drop  [2];
  logic   win_valid;
  logic   win_src;
  logic   active;

  assign active = rdy && !misbranch_flag;

  always_comb begin
    in_entry[0] = '{id: alu_rob_id, data: alu_result};
    in_entry[1] = '{id: ls_rob_id, data: ls_result};
    push[0]     = alu_valid && (alu_rob_id != '0) && active;
    push[1]     = ls_valid && (ls_rob_id != '0) && active;

    for (int s = 0; s < 2; s++) begin
      empty[s]      = (count_q[s] == '0);
      full[s]       = (count_q[s] == CntW'(FIFO_DEPTH));
      cand[s]       = active && (!empty[s] || push[s]);
      cand_entry[s] = empty[s] ? in_entry[s] : mem_q[s][rd_ptr_q[s]];
    end

    // With both sides requesting, the side that did not win last time goes.
    win_valid = cand[0] || cand[1];
    win_src   = (cand[0] && cand[1]) ? ~last_grant_q : cand[1];
    grant[0]  = win_valid && (win_src == SrcAlu);
    grant[1]  = win_valid && (win_src == SrcLs);

    for (int s = 0; s < 2; s++) begin
      deq[s]  = grant[s] && !empty[s];
      enq[s]  = push[s] && !(grant[s] && empty[s]) && (!full[s] || deq[s]);
      drop[s] = push[s] && !(grant[s] && empty[s]) && full[s] && !deq[s];
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    cdb_valid_d  = rdy ? win_valid : cdb_valid_q;
    cdb_src_d    = cdb_src_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_result_d = cdb_result_q;
    overflow_d   = overflow_q | drop[0] | drop[1];

    for (int s = 0; s < 2; s++) begin
      rd_ptr_d[s] = deq[s] ? rd_ptr_q[s] + PtrW'(1) : rd_ptr_q[s];
      wr_ptr_d[s] = enq[s] ? wr_ptr_q[s] + PtrW'(1) : wr_ptr_q[s];
      count_d[s]  = count_q[s] + CntW'(enq[s]) - CntW'(deq[s]);
    end

    if (win_valid) begin
      last_grant_d = win_src;
      cdb_src_d    = win_src;
      cdb_rob_id_d = cand_entry[win_src].id;
      cdb_result_d = cand_entry[win_src].data;
    end

    if (rdy && misbranch_flag) begin
      last_grant_d = SrcLs;
      for (int s = 0; s < 2; s++) begin
        rd_ptr_d[s] = '0;
        wr_ptr_d[s] = '0;
        count_d[s]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= SrcLs;
      cdb_valid_q  <= 1'b0;
      cdb_src_q    <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_result_q <= '0;
      overflow_q   <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        rd_ptr_q[s] <= '0;
        wr_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_src_q    <= cdb_src_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_result_q <= cdb_result_d;
      overflow_q   <= overflow_d;
      for (int s = 0; s < 2; s++) begin
        rd_ptr_q[s] <= rd_ptr_d[s];
        wr_ptr_q[s] <= wr_ptr_d[s];
        count_q[s]  <= count_d[s];
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (enq[s]) mem_q[s][wr_ptr_q[s]] <= in_entry[s];
    end
  end

  assign alu_ready    = (count_q[0] != CntW'(FIFO_DEPTH));
  assign ls_ready     = (count_q[1] != CntW'(FIFO_DEPTH));
  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_id   = cdb_rob_id_q;
  assign cdb_result   = cdb_result_q;
  assign cdb_src      = cdb_src_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, bypass, contention, overflow, flush, stall and
// asynchronous reset, with expected broadcasts worked out by hand from the arbitration rules.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        misbranch_flag = 1'b0;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_rob_id = '0;
  logic [31:0] alu_result = '0;
  logic        alu_ready;
  logic        ls_valid = 1'b0;
  logic [3:0]  ls_rob_id = '0;
  logic [31:0] ls_result = '0;
  logic        ls_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_result;
  logic        cdb_src;
  logic        overflow_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  cdb_arbiter #(
    .DATA_WIDTH  (32),
    .ROB_ID_WIDTH(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .misbranch_flag(misbranch_flag),
    .alu_valid     (alu_valid),
    .alu_rob_id    (alu_rob_id),
    .alu_result    (alu_result),
    .alu_ready     (alu_ready),
    .ls_valid      (ls_valid),
    .ls_rob_id     (ls_rob_id),
    .ls_result     (ls_result),
    .ls_ready      (ls_ready),
    .cdb_valid     (cdb_valid),
    .cdb_rob_id    (cdb_rob_id),
    .cdb_result    (cdb_result),
    .cdb_src       (cdb_src),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bcast(input string tag, input logic src, input logic [3:0] id,
                             input logic [31:0] data);
    check({tag, " valid"}, 32'(cdb_valid), 32'd1);
    check({tag, " src"}, 32'(cdb_src), 32'(src));
    check({tag, " id"}, 32'(cdb_rob_id), 32'(id));
    check({tag, " data"}, cdb_result, data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [3:0] id, input logic [31:0] d);
    alu_valid = v; alu_rob_id = id; alu_result = d;
  endtask

  task automatic set_ls(input logic v, input logic [3:0] id, input logic [31:0] d);
    ls_valid = v; ls_rob_id = id; ls_result = d;
  endtask

  // Flushes and leaves last_grant = LS so ALU wins the next contention.
  task automatic flush_pulse();
    misbranch_flag = 1'b1;
    tick();
    misbranch_flag = 1'b0;
  endtask

  initial begin
    logic        exp_src;
    logic [3:0]  exp_n;
    logic [31:0] base;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", 32'(cdb_valid), 32'd0);
    check("rst id", 32'(cdb_rob_id), 32'd0);
    check("rst data", cdb_result, 32'd0);
    check("rst src", 32'(cdb_src), 32'd0);
    check("rst ovf", 32'(overflow_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle valid", 32'(cdb_valid), 32'd0);
      check("idle ready", {30'd0, alu_ready, ls_ready}, 32'd3);
    end

    // Single bypass
    set_alu(1'b1, 4'd3, 32'h1234);
    tick();
    set_alu(1'b0, 4'd0, 32'h0);
    check_bcast("bypass", 1'b0, 4'd3, 32'h1234);
    tick();
    check("bypass drop", 32'(cdb_valid), 32'd0);
    check("bypass hold id", 32'(cdb_rob_id), 32'd3);

    // rob_id 0 push is ignored
    set_alu(1'b1, 4'd0, 32'hDEAD);
    tick();
    set_alu(1'b0, 4'd0, 32'h0);
    check("zero id", 32'(cdb_valid), 32'd0);

    // Contention: 1/2 then 4/5 back to back -> 1(A), 2(L), 4(A), 5(L)
    flush_pulse();
    set_alu(1'b1, 4'd1, 32'h101);
    set_ls(1'b1, 4'd2, 32'h202);
    tick();
    check_bcast("cont0", 1'b0, 4'd1, 32'h101);
    set_alu(1'b1, 4'd4, 32'h404);
    set_ls(1'b1, 4'd5, 32'h505);
    tick();
    set_alu(1'b0, 4'd0, 32'h0);
    set_ls(1'b0, 4'd0, 32'h0);
    check_bcast("cont1", 1'b1, 4'd2, 32'h202);
    tick();
    check_bcast("cont2", 1'b0, 4'd4, 32'h404);
    tick();
    check_bcast("cont3", 1'b1, 4'd5, 32'h505);
    tick();
    check("cont end", 32'(cdb_valid), 32'd0);

    // Overflow: both sides push n=1..10. Grants alternate A,L; a10 and l9 are dropped.
    flush_pulse();
    for (int k = 1; k <= 18; k++) begin
      if (k <= 10) begin
        set_alu(1'b1, 4'(k), 32'hA000 + 32'(k));
        set_ls(1'b1, 4'(k), 32'hB000 + 32'(k));
      end else begin
        set_alu(1'b0, 4'd0, 32'h0);
        set_ls(1'b0, 4'd0, 32'h0);
      end
      tick();
      exp_src = (k % 2 == 0);
      exp_n   = 4'((k + 1) / 2);
      if (k == 18) exp_n = 4'd10;
      base = exp_src ? 32'hB000 : 32'hA000;
      check_bcast($sformatf("ovf%0d", k), exp_src, exp_n, base + 32'(exp_n));
      if (k == 7) check("ovf alu_ready7", 32'(alu_ready), 32'd1);
      if (k == 8) begin
        check("ovf alu_ready8", 32'(alu_ready), 32'd0);
        check("ovf err8", 32'(overflow_err), 32'd0);
      end
      if (k == 9) check("ovf err9", 32'(overflow_err), 32'd1);
    end
    set_alu(1'b0, 4'd0, 32'h0);
    set_ls(1'b0, 4'd0, 32'h0);
    tick();
    check("ovf drained", 32'(cdb_valid), 32'd0);
    check("ovf ready", {30'd0, alu_ready, ls_ready}, 32'd3);

    // Flush: after 6 paired pushes ALU holds 3 entries, LS holds 3
    flush_pulse();
    for (int k = 1; k <= 6; k++) begin
      set_alu(1'b1, 4'(k), 32'hC000 + 32'(k));
      set_ls(1'b1, 4'(k), 32'hD000 + 32'(k));
      tick();
      exp_src = (k % 2 == 0);
      exp_n   = 4'((k + 1) / 2);
      base    = exp_src ? 32'hD000 : 32'hC000;
      check_bcast($sformatf("fill%0d", k), exp_src, exp_n, base + 32'(exp_n));
    end
    set_alu(1'b1, 4'd14, 32'hC00E);
    set_ls(1'b1, 4'd14, 32'hD00E);
    misbranch_flag = 1'b1;
    tick();
    misbranch_flag = 1'b0;
    set_alu(1'b0, 4'd0, 32'h0);
    set_ls(1'b0, 4'd0, 32'h0);
    check("flush valid", 32'(cdb_valid), 32'd0);
    check("flush ready", {30'd0, alu_ready, ls_ready}, 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush idle", 32'(cdb_valid), 32'd0);
    end
    set_alu(1'b1, 4'd9, 32'hE009);
    tick();
    set_alu(1'b0, 4'd0, 32'h0);
    check_bcast("post flush", 1'b0, 4'd9, 32'hE009);
    tick();
    check("post flush end", 32'(cdb_valid), 32'd0);

    // rdy stall: id 7 on the bus, LS 8 queued; pushes during stall ignored
    flush_pulse();
    set_alu(1'b1, 4'd7, 32'h77);
    set_ls(1'b1, 4'd8, 32'h88);
    tick();
    set_ls(1'b0, 4'd0, 32'h0);
    check_bcast("stall pre", 1'b0, 4'd7, 32'h77);
    rdy = 1'b0;
    set_alu(1'b1, 4'd12, 32'hCC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bcast($sformatf("stall%0d", i), 1'b0, 4'd7, 32'h77);
    end
    rdy = 1'b1;
    set_alu(1'b0, 4'd0, 32'h0);
    tick();
    check_bcast("resume", 1'b1, 4'd8, 32'h88);
    tick();
    check("resume end", 32'(cdb_valid), 32'd0);

    // Asynchronous reset mid-burst
    flush_pulse();
    set_alu(1'b1, 4'd5, 32'h55);
    set_ls(1'b1, 4'd6, 32'h66);
    tick();
    set_alu(1'b0, 4'd0, 32'h0);
    set_ls(1'b0, 4'd0, 32'h0);
    check_bcast("burst", 1'b0, 4'd5, 32'h55);
    check("ovf sticky", 32'(overflow_err), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async valid", 32'(cdb_valid), 32'd0);
    check("async id", 32'(cdb_rob_id), 32'd0);
    check("async data", cdb_result, 32'd0);
    check("async ovf", 32'(overflow_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after rst", 32'(cdb_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
